// File: rtl/router_mcast_input_unit.sv
// Multicast router input unit: flit FIFO plus per-output request and
// served tracking; a flit is dequeued once every output in its mask took it.
module router_mcast_input_unit #(
  parameter int FlitWidth = 34,
  parameter int FifoDepth = 4,
  parameter int MaskLsb   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FlitWidth-1:0] data_in,
  input  logic                 data_void_in,
  output logic                 stop_out,
  output logic [FlitWidth-1:0] data_out,
  output logic [4:0]           request,
  input  logic [4:0]           grant,
  input  logic [4:0]           out_ready,
  output logic [4:0]           forwarding_head,
  output logic [4:0]           forwarding_tail,
  output logic                 proto_err
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {
    IDLE,
    PACKET,
    DROP
  } state_e;

  state_e               state_q, state_d;
  logic [FlitWidth-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [4:0]           pkt_mask_q, pkt_mask_d;
  logic [4:0]           served_q, served_d;

  logic [FlitWidth-1:0] head_flit;
  logic [4:0]           hmask, mask, fwd;
  logic                 empty, full, push, pop;
  logic                 is_head, is_tail, bad_hd;
  logic                 done, drop_one;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CntW'(FifoDepth));
    head_flit = mem_q[rd_ptr_q];
    is_head   = !empty && head_flit[FlitWidth-1];
    is_tail   = !empty && head_flit[FlitWidth-2];
    hmask     = head_flit[MaskLsb +: 5];

    mask = '0;
    case (state_q)
      IDLE:    mask = is_head ? hmask : 5'b0;
      PACKET:  mask = pkt_mask_q;
      default: mask = '0;
    endcase

    request = empty ? 5'b0 : (mask & ~served_q);
    fwd     = request & grant & out_ready;
    forwarding_head = is_head ? fwd : 5'b0;
    forwarding_tail = is_tail ? fwd : 5'b0;

    done = !empty && (mask != 5'b0)
        && ((served_q | fwd) == mask);

    // Orphan body flit or unroutable head found while idle.
    bad_hd = !empty && (state_q == IDLE)
          && (!is_head || (hmask == 5'b0));
    proto_err = bad_hd;

    drop_one = bad_hd
            || (!empty && (state_q == DROP));
    pop  = done || drop_one;
    push = !data_void_in && !full;

    stop_out = full;
    data_out = empty ? '0 : head_flit;
  end

  always_comb begin
    state_d    = state_q;
    pkt_mask_d = pkt_mask_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (done) begin
          pkt_mask_d = mask;
          if (!is_tail) state_d = PACKET;
        end else if (bad_hd && is_head && !is_tail) begin
          state_d = DROP;
        end
      end
      (state_q == PACKET): begin
        if (done && is_tail) begin
          state_d    = IDLE;
          pkt_mask_d = '0;
        end
      end
      (state_q == DROP): begin
        if (is_tail) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    served_d = pop ? 5'b0 : (served_q | fwd);
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pkt_mask_q <= '0;
      served_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pkt_mask_q <= pkt_mask_d;
      served_q   <= served_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

`ifndef SYNTHESIS
  a_fwd_req: assert property (
    @(posedge clk) disable iff (!rst)
    (fwd & ~request) == 5'b0);

  c_push_full: cover property (
    @(posedge clk) disable iff (!rst)
    full && !data_void_in);
`endif

endmodule

// File: tb/tb_router_mcast_input_unit.sv
// Directed bench for router_mcast_input_unit: per-cycle vector table
// plus hand sequences for backpressure and reset mid-packet.
module tb_router_mcast_input_unit;

  logic        clk;
  logic        rst;
  logic [33:0] data_in;
  logic        data_void_in;
  logic        stop_out;
  logic [33:0] data_out;
  logic [4:0]  request;
  logic [4:0]  grant;
  logic [4:0]  out_ready;
  logic [4:0]  forwarding_head;
  logic [4:0]  forwarding_tail;
  logic        proto_err;

  int checks;
  int failures;

  router_mcast_input_unit dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .data_void_in    (data_void_in),
    .stop_out        (stop_out),
    .data_out        (data_out),
    .request         (request),
    .grant           (grant),
    .out_ready       (out_ready),
    .forwarding_head (forwarding_head),
    .forwarding_tail (forwarding_tail),
    .proto_err       (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] din;
    logic        vd;
    logic [4:0]  gnt;
    logic [4:0]  rdy;
    logic        stop;
    logic [4:0]  req;
    logic [4:0]  fh;
    logic [4:0]  ft;
    logic        perr;
    logic [33:0] dout;
  } vec_t;

  function automatic logic [33:0] mk(
    input logic       h,
    input logic       t,
    input logic [7:0] pl,
    input logic [4:0] m
  );
    return {h, t, 19'b0, pl, m};
  endfunction

  function automatic vec_t vec(
    input logic [33:0] din,
    input logic        vd,
    input logic [4:0]  gnt,
    input logic [4:0]  rdy,
    input logic        stop,
    input logic [4:0]  req,
    input logic [4:0]  fh,
    input logic [4:0]  ft,
    input logic        perr,
    input logic [33:0] dout
  );
    vec_t r;
    r.din  = din;
    r.vd   = vd;
    r.gnt  = gnt;
    r.rdy  = rdy;
    r.stop = stop;
    r.req  = req;
    r.fh   = fh;
    r.ft   = ft;
    r.perr = perr;
    r.dout = dout;
    return r;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [33:0] act,
    input logic [33:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic [33:0] din,
    input logic        vd,
    input logic [4:0]  gnt,
    input logic [4:0]  rdy
  );
    data_in      = din;
    data_void_in = vd;
    grant        = gnt;
    out_ready    = rdy;
  endtask

  task automatic chk_all(
    input string       tag,
    input logic        stop,
    input logic [4:0]  req,
    input logic [4:0]  fh,
    input logic [4:0]  ft,
    input logic        perr,
    input logic [33:0] dout
  );
    chk({tag, " stop"}, 34'(stop_out), 34'(stop));
    chk({tag, " req"}, 34'(request), 34'(req));
    chk({tag, " fh"}, 34'(forwarding_head), 34'(fh));
    chk({tag, " ft"}, 34'(forwarding_tail), 34'(ft));
    chk({tag, " perr"}, 34'(proto_err), 34'(perr));
    chk({tag, " dout"}, data_out, dout);
  endtask

  localparam logic [4:0] A = 5'b11111;
  localparam logic [4:0] N = 5'b00000;

  vec_t        v [23];
  logic [33:0] f1, h, b, t, z, d1, d2, bx, ht0, u2;
  logic [33:0] p [5];
  logic [33:0] h2, b2, u3;

  initial begin
    checks   = 0;
    failures = 0;

    f1  = mk(1, 1, 8'h11, 5'b00100);
    h   = mk(1, 0, 8'h21, 5'b10011);
    b   = mk(0, 0, 8'h22, 5'b01100);
    t   = mk(0, 1, 8'h23, 5'b00000);
    z   = mk(1, 0, 8'h31, 5'b00000);
    d1  = mk(0, 0, 8'h32, 5'b11111);
    d2  = mk(0, 1, 8'h33, 5'b11111);
    bx  = mk(0, 0, 8'h41, 5'b11111);
    ht0 = mk(1, 1, 8'h51, 5'b00000);
    u2  = mk(1, 1, 8'h52, 5'b01000);

    // din vd gnt rdy | stop req fh ft perr dout
    v[0]  = vec(f1, 0, N, A, 0, N, N, N, 0, 0);
    v[1]  = vec(0, 1, 5'b00100, A, 0,
                5'b00100, 5'b00100, 5'b00100, 0, f1);
    v[2]  = vec(0, 1, N, A, 0, N, N, N, 0, 0);
    v[3]  = vec(h, 0, N, A, 0, N, N, N, 0, 0);
    v[4]  = vec(b, 0, 5'b00001, A, 0,
                5'b10011, 5'b00001, N, 0, h);
    v[5]  = vec(t, 0, 5'b00001, A, 0,
                5'b10010, N, N, 0, h);
    v[6]  = vec(0, 1, 5'b10010, A, 0,
                5'b10010, 5'b10010, N, 0, h);
    v[7]  = vec(0, 1, 5'b10011, A, 0,
                5'b10011, N, N, 0, b);
    v[8]  = vec(0, 1, 5'b10011, 5'b00011, 0,
                5'b10011, N, 5'b00011, 0, t);
    v[9]  = vec(0, 1, 5'b10000, A, 0,
                5'b10000, N, 5'b10000, 0, t);
    v[10] = vec(0, 1, A, A, 0, N, N, N, 0, 0);
    v[11] = vec(z, 0, N, A, 0, N, N, N, 0, 0);
    v[12] = vec(d1, 0, A, A, 0, N, N, N, 1, z);
    v[13] = vec(d2, 0, A, A, 0, N, N, N, 0, d1);
    v[14] = vec(0, 1, A, A, 0, N, N, N, 0, d2);
    v[15] = vec(0, 1, A, A, 0, N, N, N, 0, 0);
    v[16] = vec(bx, 0, A, A, 0, N, N, N, 0, 0);
    v[17] = vec(0, 1, A, A, 0, N, N, N, 1, bx);
    v[18] = vec(0, 1, A, A, 0, N, N, N, 0, 0);
    v[19] = vec(ht0, 0, N, A, 0, N, N, N, 0, 0);
    v[20] = vec(u2, 0, N, A, 0, N, N, N, 1, ht0);
    v[21] = vec(0, 1, 5'b01000, A, 0,
                5'b01000, 5'b01000, 5'b01000, 0, u2);
    v[22] = vec(0, 1, N, A, 0, N, N, N, 0, 0);

    rst = 1'b0;
    drive(0, 1, N, A);
    repeat (2) @(negedge clk);
    #1;
    chk_all("reset", 0, N, N, N, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(v[i].din, v[i].vd, v[i].gnt, v[i].rdy);
      #1;
      chk_all($sformatf("v%0d", i), v[i].stop,
              v[i].req, v[i].fh, v[i].ft,
              v[i].perr, v[i].dout);
    end

    // Backpressure: fill with outputs stalled, then drain.
    for (int k = 0; k < 5; k++)
      p[k] = mk(1, 1, 8'h60 + 8'(k), 5'b00001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(p[k], 0, A, N);
      #1;
      chk($sformatf("bp%0d stop", k),
          34'(stop_out), 34'(k == 4));
      chk($sformatf("bp%0d fh", k),
          34'(forwarding_head), 34'(0));
    end
    @(negedge clk);
    drive(p[4], 0, A, N);
    #1;
    chk("bp hold stop", 34'(stop_out), 34'(1));
    chk("bp hold dout", data_out, p[0]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 2) drive(p[4], 0, A, A);
      else       drive(0, 1, A, A);
      #1;
      chk($sformatf("drain%0d dout", k), data_out, p[k]);
      chk($sformatf("drain%0d ft", k),
          34'(forwarding_tail), 34'(5'b00001));
      chk($sformatf("drain%0d stop", k),
          34'(stop_out), 34'(k == 0));
    end
    @(negedge clk);
    drive(0, 1, A, A);
    #1;
    chk_all("drained", 0, N, N, N, 0, 0);

    // Reset while a packet is open, then route a fresh head.
    h2 = mk(1, 0, 8'h71, 5'b01001);
    b2 = mk(0, 0, 8'h72, 5'b00000);
    u3 = mk(1, 1, 8'h73, 5'b00010);
    @(negedge clk);
    drive(h2, 0, N, A);
    @(negedge clk);
    drive(b2, 0, 5'b01001, A);
    #1;
    chk_all("rm head", 0, 5'b01001, 5'b01001, N, 0, h2);
    @(negedge clk);
    drive(0, 1, N, A);
    #1;
    chk_all("rm body", 0, 5'b01001, N, N, 0, b2);
    drive(0, 1, 5'b01001, A);
    #1;
    rst = 1'b0;
    #1;
    chk_all("rm reset", 0, N, N, N, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(u3, 0, N, A);
    #1;
    chk_all("rm push", 0, N, N, N, 0, 0);
    @(negedge clk);
    drive(0, 1, 5'b00010, A);
    #1;
    chk_all("rm route", 0, 5'b00010, 5'b00010,
            5'b00010, 0, u3);
    @(negedge clk);
    drive(0, 1, N, A);
    #1;
    chk_all("rm empty", 0, N, N, N, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
